alu_control_mdu: RTL

//  Parametrised successor ALU control: decodes opcode/funct3/funct7 into alu_op for the single-cycle ALU
//  and adds RV32M decode plus a sequencer driving an iterative multiply/divide unit (MDU).

---
 rtl/alu_control_mdu_pkg.sv | 87 ++++++++
 rtl/alu_control_mdu_mdu_iter_core.sv | 116 +++++++++++
 rtl/alu_control_mdu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_control_mdu_pkg.sv
// Shared encodings for alu_control_mdu: RV32I/M opcode and funct fields, ALU op codes, MDU states.
package alu_control_mdu_pkg;

    localparam logic [6:0] OPC_LOAD       = 7'b0000011;
    localparam logic [6:0] OPC_STORE      = 7'b0100011;
    localparam logic [6:0] OPC_ARITH_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_ARITHMETIC = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
    localparam logic [6:0] OPC_JALR       = 7'b1100111;

    localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [7:0] {
        ALU_ADD    = 8'd0,  ALU_SUB    = 8'd1,  ALU_SLL    = 8'd2,  ALU_SLT    = 8'd3,
        ALU_SLTU   = 8'd4,  ALU_XOR    = 8'd5,  ALU_SRL    = 8'd6,  ALU_SRA    = 8'd7,
        ALU_OR     = 8'd8,  ALU_AND    = 8'd9,  ALU_BEQ    = 8'd10, ALU_BNE    = 8'd11,
        ALU_BLT    = 8'd12, ALU_BGE    = 8'd13, ALU_BLTU   = 8'd14, ALU_BGEU   = 8'd15,
        ALU_MUL    = 8'd16, ALU_MULH   = 8'd17, ALU_MULHSU = 8'd18, ALU_MULHU  = 8'd19,
        ALU_DIV    = 8'd20, ALU_DIVU   = 8'd21, ALU_REM    = 8'd22, ALU_REMU   = 8'd23
    } alu_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} mdu_state_e;

    function automatic alu_op_e base_op(input logic [2:0] f3);
        case (f3)
            FUNCT3_SLL:  return ALU_SLL;
            FUNCT3_SLT:  return ALU_SLT;
            FUNCT3_SLTU: return ALU_SLTU;
            FUNCT3_XOR:  return ALU_XOR;
            FUNCT3_SR:   return ALU_SRL;
            FUNCT3_OR:   return ALU_OR;
            FUNCT3_AND:  return ALU_AND;
            default:     return ALU_ADD;
        endcase
    endfunction

    function automatic alu_op_e branch_op(input logic [2:0] f3);
        case (f3)
            FUNCT3_BNE:  return ALU_BNE;
            FUNCT3_BLT:  return ALU_BLT;
            FUNCT3_BGE:  return ALU_BGE;
            FUNCT3_BLTU: return ALU_BLTU;
            FUNCT3_BGEU: return ALU_BGEU;
            default:     return ALU_BEQ;
        endcase
    endfunction

    function automatic alu_op_e muldiv_op(input logic [2:0] f3);
        case (f3)
            FUNCT3_MULH:   return ALU_MULH;
            FUNCT3_MULHSU: return ALU_MULHSU;
            FUNCT3_MULHU:  return ALU_MULHU;
            FUNCT3_DIV:    return ALU_DIV;
            FUNCT3_DIVU:   return ALU_DIVU;
            FUNCT3_REM:    return ALU_REM;
            FUNCT3_REMU:   return ALU_REMU;
            default:       return ALU_MUL;
        endcase
    endfunction

endpackage

// File: rtl/alu_control_mdu_mdu_iter_core.sv
// MDU datapath: shift-add multiplier, restoring divider, sign fixup and the result register.
// FAST_MUL_EN replaces the iterative multiply with a single-cycle combinational one.
module mdu_iter_core
    import alu_control_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            step,
    input  logic            finish,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            quick,
    output logic [XLEN-1:0] result
);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] prod, input logic neg,
                                                input logic [2:0] f3);
        logic [2*XLEN-1:0] p;
        p = neg ? -prod : prod;
        return (f3 == FUNCT3_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_fix(input logic [2*XLEN-1:0] acc, input logic neg_q,
                                                input logic neg_r, input logic [2:0] f3);
        logic [XLEN-1:0] q, r;
        q = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        return f3[1] ? r : q;
    endfunction

    logic            signed_a, signed_b, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, quick_res, result_q;

    // MULHSU treats only rs1 as signed; the unsigned forms never negate.
    assign signed_a = (funct3 != FUNCT3_MULHU) && (funct3 != FUNCT3_DIVU) && (funct3 != FUNCT3_REMU);
    assign signed_b = signed_a && (funct3 != FUNCT3_MULHSU);
    assign neg_a    = signed_a & rs1_data[XLEN-1];
    assign neg_b    = signed_b & rs2_data[XLEN-1];
    assign a_mag    = neg_a ? -rs1_data : rs1_data;
    assign b_mag    = neg_b ? -rs2_data : rs2_data;
    assign div_zero = funct3[2] && (rs2_data == '0);
    assign div_ovf  = funct3[2] && signed_b && (rs1_data == MIN_VAL) && (rs2_data == '1);

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
`endif

    always_comb begin
        quick     = 1'b0;
        quick_res = '0;
        if (div_zero) begin
            quick     = 1'b1;
            quick_res = funct3[1] ? rs1_data : '1;
        end else if (div_ovf) begin
            quick     = 1'b1;
            quick_res = funct3[1] ? '0 : MIN_VAL;
        end
`ifdef FAST_MUL_EN
        else if (!funct3[2]) begin
            quick     = 1'b1;
            quick_res = mul_fix(fast_prod, neg_a ^ neg_b, funct3);
        end
`endif
    end

    logic [2:0]        f3_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;

    // acc holds {product_hi, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_diff = rem_sh - {1'b0, opnd_q};
        if (f3_q[2]) begin
            acc_d = {div_diff[XLEN] ? rem_sh[XLEN-1:0] : div_diff[XLEN-1:0],
                     acc_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            f3_q    <= funct3;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            opnd_q  <= funct3[2] ? b_mag : a_mag;
            acc_q   <= {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
        end else if (step) begin
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
        end else if (start && quick) begin
            result_q <= quick_res;
        end else if (finish) begin
            result_q <= f3_q[2] ? div_fix(acc_d, neg_a_q ^ neg_b_q, neg_a_q, f3_q)
                                : mul_fix(acc_d, neg_a_q ^ neg_b_q, f3_q);
        end
    end

    assign result = result_q;

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control with RV32M decode and the sequencer for the iterative MDU.
// FAST_MUL_EN (in mdu_iter_core) makes multiplies complete in one cycle.
module alu_control_mdu
    import alu_control_mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int OP_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                no_inst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    output logic [OP_WIDTH-1:0] alu_op,
    output logic                is_muldiv,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic                flush,
    output logic                mdu_busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result
);
    localparam int CNT_W = $clog2(XLEN + 1);

    alu_op_e op_sel;

    always_comb begin
        op_sel = ALU_ADD;
        if (!no_inst) begin
            case (opcode)
                OPC_ARITHMETIC: begin
                    if (funct7 == FUNCT7_MULDIV)                          op_sel = muldiv_op(funct3);
                    else if (funct7 == FUNCT7_SUB && funct3 == FUNCT3_ADD) op_sel = ALU_SUB;
                    else if (funct7 == FUNCT7_SUB && funct3 == FUNCT3_SR)  op_sel = ALU_SRA;
                    else                                                   op_sel = base_op(funct3);
                end
                // No SUBI exists, so only the shift-right immediate looks at funct7.
                OPC_ARITH_IMM: op_sel = (funct3 == FUNCT3_SR && funct7[5]) ? ALU_SRA : base_op(funct3);
                OPC_BRANCH:    op_sel = branch_op(funct3);
                OPC_LOAD, OPC_STORE, OPC_JALR: op_sel = ALU_ADD;
                default:       op_sel = ALU_ADD;
            endcase
        end
    end

    assign alu_op    = OP_WIDTH'(op_sel);
    assign is_muldiv = !no_inst && (opcode == OPC_ARITHMETIC) && (funct7 == FUNCT7_MULDIV);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, quick, step, finish;

    assign in_ready  = (state_q == ST_IDLE) && !flush;
    assign accept    = in_valid && is_muldiv && in_ready;
    assign mdu_busy  = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (quick) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = funct3[2] ? ST_DIV : ST_MUL;
                        cnt_d   = CNT_W'(XLEN);
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    // The last step's value is fixed up and latched in the same edge.
                    if (cnt_q == CNT_W'(1)) begin
                        finish  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (flush || out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mdu_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (accept),
        .step     (step),
        .finish   (finish),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .quick    (quick),
        .result   (result)
    );

endmodule
